// File: rtl/deshifter_pkg.sv
// Shared constants for the serial shifter/deshifter pair. Both ends take the
// default word MSB index from here so their word sizes always agree.
package deshifter_pkg;

    // Index of the word MSB; the serial word is WORD_MSB+1 bits wide.
    localparam int WORD_MSB = 7;

endpackage : deshifter_pkg

// File: rtl/deshifter.sv
// Serial-to-parallel deshifter. Collects MSB-first bits qualified by valid,
// presents each completed word on data with a full/read handshake, and flags
// a dropped word with a sticky overrun bit.
module deshifter
    import deshifter_pkg::*;
#(
    parameter int WIDTH = WORD_MSB
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             valid,
    input  logic             read,
    output logic [WIDTH:0]   data,
    output logic             full,
    output logic             overrun,
    output logic             busy
);

    localparam int PW = (WIDTH > 0) ? $clog2(WIDTH + 1) : 1;

    logic [WIDTH:0]  buffer;
    logic [PW-1:0]   position;
    logic            complete;
    logic [WIDTH:0]  word;

    // The accepted bit is folded in combinationally so a completed word
    // includes the bit arriving on the completion edge.
    assign word     = {buffer[WIDTH-1:0], in};
    assign complete = valid && (position == PW'(WIDTH));
    assign busy     = (position != '0);

    // Shift register and bit position: advance only on valid edges, wrap on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer   <= '0;
            position <= '0;
        end else if (valid) begin
            buffer   <= word;
            position <= complete ? '0 : position + PW'(1);
        end
    end

    // Hold register and flags: load when the consumer has room (or frees it
    // on this very edge), otherwise drop the word and mark overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data    <= '0;
            full    <= 1'b0;
            overrun <= 1'b0;
        end else if (complete) begin
            if (!full || read) begin
                data <= word;
                full <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (read && full) begin
            full    <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule : deshifter
